// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer, run/pause/halt FSM and perf counters.
// Define PIPELINE_CTRL_STATS_EN to build the four performance counters.
module pipeline_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_is_jump,
  input  logic                 ex_mem_to_reg,
  input  logic [REG_W-1:0]     ex_rd,
  input  logic                 ex_is_cond_branch,
  input  logic                 ex_branch_taken,
  input  logic                 wb_halt,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 pipe_en,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] total_cycles,
  output logic [CNT_WIDTH-1:0] condi_branch_num,
  output logic [CNT_WIDTH-1:0] uncondi_branch_num,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    HALT   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic load_use;
  logic rs_hit, rt_hit;
  logic br_c, lu_c, jp_c;
  logic freeze;

  assign rs_hit = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit = id_uses_rt & (id_rt == ex_rd);

  assign load_use = ex_mem_to_reg
                  & (ex_rd != '0)
                  & (rs_hit | rt_hit);

  // one-hot priority: taken branch > load-use > jump
  assign br_c = ex_is_cond_branch & ex_branch_taken;
  assign lu_c = load_use & ~br_c;
  assign jp_c = id_is_jump & ~br_c & ~load_use;

  // PAUSED only freezes while pause is still high, so the
  // pipeline advances in the very cycle pause drops.
  assign freeze = (state_q == HALT)
                | pause
                | wb_halt
                | rst;

  assign state  = state_q;
  assign halted = (state_q == HALT);

  // next-state logic; halt wins over pause, reset wins over all
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (wb_halt)    state_d = HALT;
        else if (pause) state_d = PAUSED;
      end
      PAUSED: begin
        if (wb_halt)     state_d = HALT;
        else if (!pause) state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (rst) state_d = RUN;
  end

  // state register
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // enable/flush decode
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b0;
    if (!freeze) begin
      unique case (1'b1)
        br_c: begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          pipe_en     = 1'b1;
        end
        lu_c: begin
          id_ex_flush = 1'b1;
          pipe_en     = 1'b1;
        end
        jp_c: begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          pipe_en     = 1'b1;
        end
        default: begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          pipe_en  = 1'b1;
        end
      endcase
    end
  end

`ifdef PIPELINE_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] tot_q, tot_d;
  logic [CNT_WIDTH-1:0] cbr_q, cbr_d;
  logic [CNT_WIDTH-1:0] ubr_q, ubr_d;
  logic [CNT_WIDTH-1:0] stl_q, stl_d;

  // counters step only on cycles that actually advance
  always_comb begin
    tot_d = tot_q;
    cbr_d = cbr_q;
    ubr_d = ubr_q;
    stl_d = stl_q;
    if (!freeze) begin
      tot_d = tot_q + 1'b1;
      if (br_c) cbr_d = cbr_q + 1'b1;
      if (jp_c) ubr_d = ubr_q + 1'b1;
      if (lu_c) stl_d = stl_q + 1'b1;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tot_q <= '0;
      cbr_q <= '0;
      ubr_q <= '0;
      stl_q <= '0;
    end else begin
      tot_q <= tot_d;
      cbr_q <= cbr_d;
      ubr_q <= ubr_d;
      stl_q <= stl_d;
    end
  end

  assign total_cycles       = tot_q;
  assign condi_branch_num   = cbr_q;
  assign uncondi_branch_num = ubr_q;
  assign stall_cycles       = stl_q;
`else
  assign total_cycles       = '0;
  assign condi_branch_num   = '0;
  assign uncondi_branch_num = '0;
  assign stall_cycles       = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl.
// Counter expectations collapse to 0 unless PIPELINE_CTRL_STATS_EN.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_is_jump, ex_mem_to_reg;
  logic        ex_is_cond_branch, ex_branch_taken;
  logic        wb_halt;
  logic        pc_en, if_id_en, if_id_flush;
  logic        id_ex_flush, pipe_en, halted;
  logic [1:0]  state;
  logic [31:0] total_cycles, condi_branch_num;
  logic [31:0] uncondi_branch_num, stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  pipeline_ctrl #(.CNT_WIDTH(32), .REG_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .pause              (pause),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_uses_rs         (id_uses_rs),
    .id_uses_rt         (id_uses_rt),
    .id_is_jump         (id_is_jump),
    .ex_mem_to_reg      (ex_mem_to_reg),
    .ex_rd              (ex_rd),
    .ex_is_cond_branch  (ex_is_cond_branch),
    .ex_branch_taken    (ex_branch_taken),
    .wb_halt            (wb_halt),
    .pc_en              (pc_en),
    .if_id_en           (if_id_en),
    .if_id_flush        (if_id_flush),
    .id_ex_flush        (id_ex_flush),
    .pipe_en            (pipe_en),
    .halted             (halted),
    .state              (state),
    .total_cycles       (total_cycles),
    .condi_branch_num   (condi_branch_num),
    .uncondi_branch_num (uncondi_branch_num),
    .stall_cycles       (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ce(input logic [31:0] v);
`ifdef PIPELINE_CTRL_STATS_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // pc_en,if_id_en,if_id_flush,id_ex_flush,pipe_en
  task automatic chk_en(input string tag,
                        input logic [4:0] exp);
    chk(tag, {27'd0, pc_en, if_id_en, if_id_flush,
              id_ex_flush, pipe_en}, {27'd0, exp});
  endtask

  task automatic chk_cnt(input string tag,
                         input int t, input int c,
                         input int u, input int s);
    chk({tag, "_tot"}, total_cycles, ce(t));
    chk({tag, "_cbr"}, condi_branch_num, ce(c));
    chk({tag, "_ubr"}, uncondi_branch_num, ce(u));
    chk({tag, "_stl"}, stall_cycles, ce(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0;
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_jump = 1'b0; ex_mem_to_reg = 1'b0;
    ex_is_cond_branch = 1'b0; ex_branch_taken = 1'b0;
    wb_halt = 1'b0;

    @(negedge clk);
    chk_en("rst_en", 5'b00000);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk_en("idle_en", 5'b11001);
    chk_cnt("rst", 0, 0, 0, 0);
    repeat (5) tick();
    chk_cnt("free5", 5, 0, 0, 0);

    // load-use on rt
    ex_mem_to_reg = 1'b1; ex_rd = 5'd8;
    id_uses_rt = 1'b1; id_rt = 5'd8;
    @(negedge clk);
    chk_en("lu_en", 5'b00011);
    tick();
    chk_cnt("lu", 6, 0, 0, 1);

    // r0 never hazards
    ex_rd = 5'd0; id_rt = 5'd0;
    @(negedge clk);
    chk_en("r0_en", 5'b11001);
    tick();
    chk_cnt("r0", 7, 0, 0, 1);

    // taken branch overrides load-use
    ex_rd = 5'd8; id_rt = 5'd8;
    ex_is_cond_branch = 1'b1; ex_branch_taken = 1'b1;
    @(negedge clk);
    chk_en("br_en", 5'b11111);
    tick();
    chk_cnt("br", 8, 1, 0, 1);

    // jump held by load-use, then proceeds
    ex_is_cond_branch = 1'b0; ex_branch_taken = 1'b0;
    id_is_jump = 1'b1;
    @(negedge clk);
    chk_en("jlu_en", 5'b00011);
    tick();
    chk_cnt("jlu", 9, 1, 0, 2);
    ex_mem_to_reg = 1'b0;
    @(negedge clk);
    chk_en("jmp_en", 5'b11101);
    tick();
    chk_cnt("jmp", 10, 1, 1, 2);
    id_is_jump = 1'b0; id_uses_rt = 1'b0;

    // pause three cycles
    pause = 1'b1;
    @(negedge clk);
    chk_en("p0_en", 5'b00000);
    chk("p0_state", {30'd0, state}, 32'd0);
    tick();
    chk("p1_state", {30'd0, state}, 32'd1);
    chk_en("p1_en", 5'b00000);
    tick();
    chk("p2_state", {30'd0, state}, 32'd1);
    tick();
    pause = 1'b0;
    @(negedge clk);
    chk("p3_state", {30'd0, state}, 32'd1);
    chk_en("p3_en", 5'b11001);
    chk_cnt("pz", 10, 1, 1, 2);
    tick();
    chk("pr_state", {30'd0, state}, 32'd0);
    chk_cnt("pr", 11, 1, 1, 2);

    // halt with pause; halt wins and sticks
    wb_halt = 1'b1; pause = 1'b1;
    @(negedge clk);
    chk_en("h0_en", 5'b00000);
    tick();
    wb_halt = 1'b0; pause = 1'b0;
    @(negedge clk);
    chk("h1_state", {30'd0, state}, 32'd2);
    chk("h1_halted", {31'd0, halted}, 32'd1);
    chk_en("h1_en", 5'b00000);
    tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    tick();
    chk("h2_state", {30'd0, state}, 32'd2);
    chk_cnt("h2", 11, 1, 1, 2);

    // reset out of halt
    rst = 1'b1;
    @(negedge clk);
    chk_en("hr_en", 5'b00000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("hr_state", {30'd0, state}, 32'd0);
    chk("hr_halted", {31'd0, halted}, 32'd0);
    chk_en("hr_run_en", 5'b11001);
    chk_cnt("hr", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
